// File: rtl/melody_sequencer_if.sv
// Control and ROM bundle between the melody sequencer (master) and its environment (slave).
// ADDR_W must match the sequencer's $clog2(SONG_LEN).
interface melody_sequencer_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              play;
  logic              stop;
  logic              pause;
  logic [ADDR_W-1:0] rom_addr;
  logic [8:0]        rom_data;
  logic [3:0]        note;
  logic              octave_up;
  logic              octave_down;
  logic              busy;
  logic              done;

  modport master (
    input  play, stop, pause, rom_data,
    output rom_addr, note, octave_up, octave_down, busy, done
  );

  modport slave (
    output play, stop, pause, rom_data,
    input  rom_addr, note, octave_up, octave_down, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Walks a song ROM and drives the buzzer note/octave controls with a per-note articulation gap.
// Define SEQ_LOOP_EN to restart the song from entry 0 after each pass instead of going idle.
module melody_sequencer #(
  parameter int unsigned TICKS_PER_UNIT = 12500000,
  parameter int unsigned GAP_TICKS      = 1250000,
  parameter int unsigned SONG_LEN       = 32
) (
  input logic                clk,
  input logic                rst,
  melody_sequencer_if.master bus
);
  localparam int unsigned ADDR_W = $clog2(SONG_LEN);
  localparam int unsigned CNT_W  = $clog2(8 * TICKS_PER_UNIT + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StPlay, StGap, StNext, StEnd
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         note_q, note_d;
  logic               up_q, up_d;
  logic               dn_q, dn_d;
  logic               rest_q, rest_d;

  logic [1:0] rom_oct;
  logic [3:0] rom_note;
  logic [2:0] rom_dur;
  logic       rom_rest;
  logic       frozen;

  assign {rom_oct, rom_note, rom_dur} = bus.rom_data;
  assign rom_rest = (rom_note == 4'd0) || rom_note[3];
  assign frozen   = bus.pause && ((state_q == StPlay) || (state_q == StGap));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    up_d    = up_q;
    dn_d    = dn_q;
    rest_d  = rest_q;
    case (state_q)
      StIdle: begin
        if (bus.play && !bus.stop) begin
          state_d = StFetch;
          addr_d  = '0;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        if (rom_oct == 2'b11) begin
          state_d = StEnd;
        end else begin
          state_d = StPlay;
          cnt_d   = CNT_W'((32'(rom_dur) + 32'd1) * TICKS_PER_UNIT);
          rest_d  = rom_rest;
          note_d  = rom_rest ? 4'd0 : rom_note;
          up_d    = !rom_rest && (rom_oct == 2'b01);
          dn_d    = !rom_rest && (rom_oct == 2'b10);
        end
      end
      StPlay: begin
        if (!bus.pause) begin
          cnt_d = cnt_q - CNT_W'(1);
          // A rest runs its whole span silently; a note hands its last GAP_TICKS to StGap.
          if (rest_q) begin
            if (cnt_q == CNT_W'(1)) state_d = StNext;
          end else if (cnt_q == CNT_W'(GAP_TICKS + 1)) begin
            state_d = (GAP_TICKS == 0) ? StNext : StGap;
          end
        end
      end
      StGap: begin
        if (!bus.pause) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = StNext;
        end
      end
      StNext: begin
        if (addr_q == ADDR_W'(SONG_LEN - 1)) begin
          state_d = StEnd;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      StEnd: begin
        addr_d = '0;
`ifdef SEQ_LOOP_EN
        state_d = StFetch;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    if (state_d != StPlay) begin
      note_d = 4'd0;
      up_d   = 1'b0;
      dn_d   = 1'b0;
    end

    if (bus.stop && (state_q != StIdle)) begin
      state_d = StIdle;
      addr_d  = '0;
      cnt_d   = '0;
      note_d  = 4'd0;
      up_d    = 1'b0;
      dn_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      note_q  <= 4'd0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      rest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      rest_q  <= rest_d;
    end
  end

  // Pause silences the outputs in the same cycle it is seen, without touching the held note.
  assign bus.rom_addr    = addr_q;
  assign bus.note        = frozen ? 4'd0 : note_q;
  assign bus.octave_up   = up_q && !frozen;
  assign bus.octave_down = dn_q && !frozen;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StEnd);
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: checkpoint table, directed corner sequences and random songs
// compared against a per-cycle expected stream built from the song contents.
module tb_melody_sequencer;
  localparam int unsigned T = 10;
  localparam int unsigned G = 2;
  localparam int unsigned L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  melody_sequencer_if #(.ADDR_W(2)) bus_if ();

  melody_sequencer #(
    .TICKS_PER_UNIT(T),
    .GAP_TICKS     (G),
    .SONG_LEN      (L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  logic [8:0] rom [L];
  always @(posedge clk) bus_if.rom_data <= rom[bus_if.rom_addr];

  int vecs = 0;
  int errs = 0;

  // {busy, done, note, up, down, addr}
  logic [9:0] act;
  assign act = {bus_if.busy, bus_if.done, bus_if.note, bus_if.octave_up, bus_if.octave_down,
                bus_if.rom_addr};
  localparam logic [9:0] IDLE_V = 10'd0;

  task automatic chk(input string name, input logic [9:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (busy,done,note,up,down,addr) at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: one element per cycle from the first FETCH to END inclusive.
  typedef struct packed {
    logic [3:0] note;
    logic       up;
    logic       dn;
    logic       done;
    logic       timed;
    logic [1:0] addr;
  } exp_t;
  exp_t q[$];

  task automatic push(input logic [3:0] n, input logic u, input logic d, input logic dn_,
                      input logic t, input int a);
    exp_t e;
    e.note = n; e.up = u; e.dn = d; e.done = dn_; e.timed = t; e.addr = a[1:0];
    q.push_back(e);
  endtask

  task automatic build_model();
    logic [1:0] oct;
    logic [3:0] nt;
    int span, aud;
    q.delete();
    for (int a = 0; a < int'(L); a++) begin
      oct = rom[a][8:7];
      nt  = rom[a][6:3];
      push(0, 0, 0, 0, 0, a);  // fetch
      push(0, 0, 0, 0, 0, a);  // load
      if (oct == 2'b11) begin
        push(0, 0, 0, 1, 0, a);
        return;
      end
      span = (int'(rom[a][2:0]) + 1) * int'(T);
      aud  = (nt == 0 || nt > 7) ? 0 : span - int'(G);
      for (int i = 0; i < span; i++) begin
        if (i < aud) push(nt, oct == 2'b01, oct == 2'b10, 0, 1, a);
        else push(0, 0, 0, 0, 1, a);
      end
      push(0, 0, 0, 0, 0, a);  // next
      if (a == int'(L) - 1) push(0, 0, 0, 1, 0, a);
    end
  endtask

  // Starts and ends at posedge+1.
  task automatic play_song(input int unsigned pause_pct, input int replay_cyc);
    exp_t e;
    logic hold;
    int n;
    build_model();
    bus_if.pause = 1'b0;
    bus_if.play  = 1'b1;
    @(negedge clk);
    chk("pre_play", IDLE_V);
    tick();
    bus_if.play = 1'b0;
    n = 0;
    while (q.size() > 0) begin
      e = q[0];
      bus_if.pause = ($urandom_range(99) < pause_pct);
      bus_if.play  = (n == replay_cyc);
      hold = bus_if.pause && e.timed;
      @(negedge clk);
      if (hold) begin
        chk("paused", {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, e.addr});
      end else begin
        chk("song", {1'b1, e.done, e.note, e.up, e.dn, e.addr});
        void'(q.pop_front());
      end
      tick();
      n++;
    end
    bus_if.pause = 1'b0;
    bus_if.play  = 1'b0;
    @(negedge clk);
`ifdef SEQ_LOOP_EN
    chk("loop_wrap", {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0});
    tick();
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    @(negedge clk);
    chk("loop_stop", IDLE_V);
`else
    chk("song_end_idle", IDLE_V);
`endif
    tick();
  endtask

  task automatic stop_pulse();
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    tick();
  endtask

  task automatic load_plan_rom();
    rom[0] = {2'b00, 4'd1, 3'd0};
    rom[1] = {2'b01, 4'd3, 3'd1};
    rom[2] = {2'b10, 4'd5, 3'd0};
    rom[3] = {2'b00, 4'd7, 3'd0};
  endtask

  typedef struct {
    int         cyc;
    logic       play;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int c, logic p, logic b, logic d, logic [3:0] n, logic u,
                              logic dn, logic [1:0] a);
    vec_t v;
    v.cyc = c; v.play = p; v.exp = {b, d, n, u, dn, a};
    return v;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    logic [3:0] en;
    bus_if.play  = 1'b0;
    bus_if.stop  = 1'b0;
    bus_if.pause = 1'b0;
    for (int i = 0; i < int'(L); i++) rom[i] = '0;

    // Reset state.
    tick();
    tick();
    @(negedge clk);
    chk("reset", IDLE_V);
    tick();
    rst = 1'b0;

    // Checkpoint table for the reference song; cycle 20 plays again while busy.
    load_plan_rom();
    tbl.push_back(mk(0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3,  0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(10, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(11, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(12, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(13, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(14, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(16, 0, 1, 0, 3, 1, 0, 1));
    tbl.push_back(mk(20, 1, 1, 0, 3, 1, 0, 1));
    tbl.push_back(mk(33, 0, 1, 0, 3, 1, 0, 1));
    tbl.push_back(mk(34, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(39, 0, 1, 0, 5, 0, 1, 2));
    tbl.push_back(mk(46, 0, 1, 0, 5, 0, 1, 2));
    tbl.push_back(mk(47, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(52, 0, 1, 0, 7, 0, 0, 3));
    tbl.push_back(mk(59, 0, 1, 0, 7, 0, 0, 3));
    tbl.push_back(mk(60, 0, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(62, 0, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(63, 0, 1, 1, 0, 0, 0, 3));
`ifdef SEQ_LOOP_EN
    tbl.push_back(mk(64, 0, 1, 0, 0, 0, 0, 0));
`else
    tbl.push_back(mk(64, 0, 0, 0, 0, 0, 0, 0));
`endif
    k = 0;
    for (int c = 0; c <= 64; c++) begin
      bus_if.play = (k < tbl.size() && tbl[k].cyc == c) ? tbl[k].play : 1'b0;
      @(negedge clk);
      if (k < tbl.size() && tbl[k].cyc == c) begin
        chk($sformatf("tbl_c%0d", c), tbl[k].exp);
        k++;
      end
      tick();
    end
    bus_if.play = 1'b0;
    stop_pulse();

    // End marker in entry 1: entries 2..3 never addressed.
    rom[0] = {2'b00, 4'd1, 3'd0};
    rom[1] = {2'b11, 4'd0, 3'd0};
    rom[2] = {2'b00, 4'd2, 3'd0};
    rom[3] = {2'b00, 4'd3, 3'd0};
    play_song(0, -1);

    // Rests (note 0 and note 9 with octave bits set) plus a play while busy.
    rom[0] = {2'b00, 4'd0, 3'd1};
    rom[1] = {2'b10, 4'd9, 3'd0};
    rom[2] = {2'b01, 4'd4, 3'd2};
    rom[3] = {2'b00, 4'd6, 3'd0};
    play_song(30, 10);

    // Pause for 7 cycles once the counter reaches 6.
    rom[0] = {2'b00, 4'd1, 3'd1};
    rom[1] = {2'b11, 4'd0, 3'd0};
    for (int c = 0; c <= 28; c++) begin
      bus_if.play  = (c == 0);
      bus_if.pause = (c >= 17 && c <= 23);
      @(negedge clk);
      if (c >= 16) begin
        en = (c == 16 || (c >= 24 && c <= 27)) ? 4'd1 : 4'd0;
        chk($sformatf("pause_c%0d", c), {1'b1, 1'b0, en, 1'b0, 1'b0, 2'd0});
      end
      tick();
    end
    bus_if.pause = 1'b0;
    stop_pulse();

    // Stop during the gap of entry 1, then stop+play in idle, then a clean restart.
    load_plan_rom();
    for (int c = 0; c <= 34; c++) begin
      bus_if.play = (c == 0);
      bus_if.stop = (c == 34);
      @(negedge clk);
      if (c == 34) chk("gap_before_stop", {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd1});
      tick();
    end
    bus_if.stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("after_stop", IDLE_V);
      tick();
    end
    bus_if.play = 1'b1;
    bus_if.stop = 1'b1;
    tick();
    bus_if.play = 1'b0;
    bus_if.stop = 1'b0;
    @(negedge clk);
    chk("stop_and_play", IDLE_V);
    tick();
    play_song(0, 6);

    // Reset mid-song.
    for (int c = 0; c <= 20; c++) begin
      bus_if.play = (c == 0);
      rst = (c == 20);
      @(negedge clk);
      if (c == 5) chk("pre_rst_play", {1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 2'd0});
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mid_song_rst", IDLE_V);
    tick();

    // Random songs with random pause and replay attempts.
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < int'(L); i++) begin
        rom[i][8:7] = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2));
        rom[i][6:3] = 4'($urandom_range(15));
        rom[i][2:0] = 3'($urandom_range(7));
      end
      play_song(25, int'($urandom_range(60)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream driver for the buzzer tone generator. Walks a song stored in an external synchronous ROM and produces the generator's note/octave controls.
- Each ROM entry gives note, octave and duration. The block times each entry with a tick counter and inserts a short silent gap before the next note for articulation.
- Controlled by play/stop/pause from the keyboard front-end; reports busy and end-of-song.

Parameters:
- TICKS_PER_UNIT, 12500000, clk cycles per duration unit (1/8 s at 100 MHz); must be > GAP_TICKS.
- GAP_TICKS, 1250000, silent cycles at the end of every non-rest note.
- SONG_LEN, 32, ROM depth in entries; address width ADDR_W = $clog2(SONG_LEN), derived as a localparam.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- play  in  1  start pulse; sampled only in IDLE
- stop  in  1  abort pulse; any state
- pause  in  1  level; freezes playback while high
- rom_addr  out  ADDR_W  ROM read address (registered)
- rom_data  in  9  entry {oct[1:0], note[3:0], dur[2:0]}; valid 1 cycle after rom_addr changes
- note  out  4  to generator; 0 = silence, 1..7 = do..si
- octave_up  out  1  to generator
- octave_down  out  1  to generator
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at song end

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: rom_addr=0, note=0, octave_up=0, octave_down=0, busy=0, done=0, state=IDLE, tick counter=0.
- Priority: rst > stop > pause > play/normal progress.

States:
- IDLE: outputs silent. play=1 -> FETCH with rom_addr=0.
- FETCH: rom_addr held for one cycle -> LOAD.
- LOAD: capture rom_data.
  - oct=11 is the end marker -> END.
  - Otherwise load tick counter with (dur+1)*TICKS_PER_UNIT; drive outputs on the next cycle -> PLAY.
- PLAY: note output follows the entry.
  - note value 0 or 8..15 is a rest: output 0, and the whole duration is silent (no GAP state).
  - oct=01 -> octave_up=1; oct=10 -> octave_down=1; oct=00 -> both 0.
  - Counter decrements each cycle. For a non-rest note, when counter==GAP_TICKS -> GAP. For a rest, when counter==0 -> NEXT.
- GAP: note=0, octave outputs 0; counter decrements to 0 -> NEXT.
- NEXT: if rom_addr==SONG_LEN-1 -> END; else rom_addr+1 -> FETCH.
- END: done=1 for exactly one cycle, outputs silent -> IDLE.

Timing and rules:
- Latency: play sampled high in cycle 0 gives FETCH in cycle 1, LOAD in cycle 2, note valid in cycle 3.
- Per-entry overhead is 3 cycles (NEXT, FETCH, LOAD), during which note=0.
- Total audible-plus-gap span per entry = (dur+1)*TICKS_PER_UNIT cycles.
- Tick counter width is $clog2(8*TICKS_PER_UNIT+1); no overflow is possible.
- pause=1 in PLAY or GAP: counter frozen, note=0, octave outputs 0, state held. On release, the remaining count resumes and outputs restore the same cycle.
- pause in FETCH/LOAD/NEXT has no effect; the freeze applies at PLAY/GAP entry.
- stop=1 in any non-IDLE state: next cycle IDLE, outputs silent, rom_addr=0, no done pulse.
- stop and play together in IDLE: stay IDLE.
- play while busy: ignored; no restart.
- rst mid-song: all outputs return to reset values on the next edge.

Optional Feature:
- SEQ_LOOP_EN defined: END still pulses done for one cycle but goes to FETCH with rom_addr=0 instead of IDLE. busy stays high. Playback continues until stop or rst.
- SEQ_LOOP_EN undefined: END -> IDLE as described above.

Test Plan:
(all with TICKS_PER_UNIT=10, GAP_TICKS=2, SONG_LEN=4)
- ROM {00,1,0},{01,3,1},{10,5,0},{00,7,0}; play pulse at cycle 0 -> note=1 during cycles 3..10, 0 during 11..12. Next: note=3 with octave_up=1 for 18 cycles. Next: note=5 with octave_down=1 for 8 cycles. Next: note=7. done pulses once; busy falls the same cycle done ends.
- Entry 1 = {11,x,x} -> after entry 0 completes, END reached; done=1 for one cycle; entries 2..3 are never addressed.
- Rest entry {00,0,1} -> note=0 for 20 cycles, no GAP state, then next fetch.
- pause held for 7 cycles mid-PLAY with counter at 6 -> note=0 while paused; after release, note returns and lasts exactly 4 more cycles before GAP.
- stop during GAP of entry 1 -> next cycle IDLE, rom_addr=0, busy=0, done never asserts. A following play restarts from entry 0. play while busy changes nothing.
- SEQ_LOOP_EN, 4-entry song -> done pulses once per pass, rom_addr wraps 3 -> 0, busy stays 1. rst mid-song -> all outputs 0 on the next cycle.
